// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM states, byte-lane layout
// of the assembled word, and the default image size limit.
package boot_pkg;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } boot_state_t;

  // Little-endian lane layout: lane 0 is bits [7:0], lane 3 is bits [31:24].
  localparam int         LANE_W     = 8;
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  // Largest image, in words, that the loader accepts by default.
  localparam int WORDS_MAX_DEFAULT = 64;

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Collects four bytes into one little-endian 32-bit word.
// word_full flags the strobe that completes the word, so the caller can
// leave its load state on the same edge that captures the last byte.
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] lane;

  // Steer each strobed byte into the current lane and advance the lane counter.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane <= LANE_FIRST;
      word <= '0;
    end else if (strobe) begin
      word[lane*LANE_W +: LANE_W] <= data;
      lane                        <= lane + 2'd1;
    end
  end

  assign word_full = strobe && (lane == LANE_LAST);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a counted byte image, writes it as words to memory
// from address 0, verifies an XOR checksum and then releases the core.
module boot_loader
  import boot_pkg::*;
#(
  parameter int WORDS_MAX = WORDS_MAX_DEFAULT,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wd,
  output logic              load_active,
  output logic              cpu_reset,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  localparam logic [7:0] MAX_N = 8'(WORDS_MAX);

  boot_state_t state, state_next;
  logic [7:0]  word_count;
  logic [7:0]  checksum;
  logic        xfer;
  logic        asm_strobe;
  logic        asm_clear;
  logic        word_full;

  // in_ready is a pure function of state, so a transfer never depends on itself.
  assign xfer = in_valid && in_ready;

  // The write address follows the number of words already committed.
  assign mem_addr = ADDR_W'({words_loaded, 2'b00});

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .strobe    (asm_strobe),
    .data      (in_data),
    .word      (mem_wd),
    .word_full (word_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= COUNT;
    else       state <= state_next;
  end

  // Next-state decode and the per-cycle strobes to the word assembler.
  always_comb begin
    state_next = state;
    asm_strobe = 1'b0;
    asm_clear  = 1'b0;
    case (state)
      COUNT: begin
        if (xfer) begin
          if (in_data > MAX_N)     state_next = ERROR;
          else if (in_data == '0)  state_next = CHECK;
          else                     state_next = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          asm_strobe = 1'b1;
          if (word_full) state_next = WRITE;
        end
      end
      WRITE: begin
        asm_clear = 1'b1;
        if (words_loaded + 8'd1 == word_count) state_next = CHECK;
        else                                   state_next = LOAD;
      end
      CHECK: begin
        if (xfer) state_next = (in_data == checksum) ? DONE : ERROR;
      end
      DONE:    state_next = DONE;
      ERROR:   state_next = ERROR;
      default: state_next = COUNT;
    endcase
  end

  // Image length, running checksum and committed word count.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_count   <= '0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      if (state == COUNT && xfer) word_count <= in_data;
      if (asm_strobe)             checksum   <= checksum ^ in_data;
      if (state == WRITE)         words_loaded <= words_loaded + 8'd1;
    end
  end

  // Registered status outputs, decoded from the state being entered so they
  // line up with the state register on every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready    <= 1'b1;
      mem_we      <= 1'b0;
      load_active <= 1'b1;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      in_ready    <= (state_next == COUNT) || (state_next == LOAD) || (state_next == CHECK);
      mem_we      <= (state_next == WRITE);
      load_active <= (state_next != DONE);
      cpu_reset   <= (state_next != DONE);
      done        <= (state_next == DONE);
      err         <= (state_next == ERROR);
    end
  end

endmodule
